sram_ctrl: RTL
==============

// Module: sram_ctrl
// PURPOSE
//  Sequences the external 512K x 16 asynchronous SRAM for the CPU memory bus.
//  Each 32-bit word request becomes two 16-bit SRAM half-accesses: low half first, then high half.
//  All SRAM strobes are driven from registers with setup, strobe and recovery phases.
//  The 16-bit tristate data pin is resolved at top level from dq_o / dq_oe / dq_i.
// PARAMETERS
//  WAIT_CYCLES  1  strobe width in clk cycles per half-access (>=1); sized for SRAM tAA/tWP
// PORTS
//  clk          in   1   single system clock
//  rst          in   1   synchronous, active-high reset
//  req_valid    in   1   request present
//  req_ready    out  1   controller idle, can accept a request
//  req_we       in   1   1=write, 0=read
//  req_addr     in   18  word address (byte address [19:2])
//  req_be       in   4   byte enables, be[0]=bits[7:0] .. be[3]=bits[31:24]
//  req_wdata    in   32  write data
//  resp_valid   out  1   one-cycle pulse: access complete
//  resp_rdata   out  32  read data, valid with resp_valid on reads
//  sram_addr    out  19  SRAM address
//  sram_ce_n    out  1   chip enable, active low
//  sram_oe_n    out  1   output enable, active low
//  sram_we_n    out  1   write enable, active low
//  sram_ub_n    out  1   upper byte enable, active low
//  sram_lb_n    out  1   lower byte enable, active low
//  sram_dq_o    out  16  data driven to SRAM
//  sram_dq_oe   out  1   1 = controller drives the data pins
//  sram_dq_i    in   16  data from SRAM
// BEHAVIOUR
//  Reset values
//  - state=IDLE; sram_ce_n/oe_n/we_n/ub_n/lb_n=1; sram_addr=0; dq_o=0; dq_oe=0.
//  - resp_valid=0; resp_rdata=0; req_ready=1 from the first cycle after reset.
//  Handshake
//  - req_ready=1 only in IDLE; a request is accepted on req_valid & req_ready.
//  - req_* are captured at accept and ignored afterwards.
//  - resp_valid pulses for 1 cycle in the cycle the FSM returns to IDLE, for reads and writes.
//  - A new request may be accepted in that same cycle, so transfers run back-to-back.
//  Address and byte mapping
//  - Low half: sram_addr={addr,0}, carries bits[15:0]; lb_n=~be[0], ub_n=~be[1].
//  - High half: sram_addr={addr,1}, carries bits[31:16]; lb_n=~be[2], ub_n=~be[3].
//  - Reads ignore req_be: lb_n=ub_n=0 and both halves are read.
//  FSM: IDLE -> SETUP -> STROBE(xWAIT_CYCLES) -> [RECOVER, writes only] -> next half or IDLE
//  - SETUP: addr and byte enables valid, ce_n=0, we_n=1, oe_n=1.
//    On writes, dq_oe=1 and dq_o=half data.
//  - STROBE, read: oe_n=0. sram_dq_i is registered into the half's resp_rdata slice
//    on the last STROBE cycle.
//  - STROBE, write: we_n=0; dq held.
//  - RECOVER (write): we_n=1; addr, dq and dq_oe held for 1 cycle to meet hold time.
//    dq_oe drops when leaving RECOVER.
//  - ce_n returns to 1 in IDLE. dq_oe is never 1 while oe_n=0.
//  Latency, accept to resp_valid (W=WAIT_CYCLES)
//  - Read: 2*(1+W)+1 cycles.
//  - Write: 2*(2+W)+1 cycles.
//  - Write skips a half whose two be bits are both 0.
//  - Write with be=0 performs no SRAM cycle; resp_valid pulses 1 cycle after accept.
//  Boundary conditions
//  - Read: resp_rdata holds its value until the next read completes; writes leave it unchanged.
//  - Addr 18'h3FFFF maps to SRAM 19'h7FFFE / 19'h7FFFF; no wrap beyond this.
//  - rst mid-access: all strobes go inactive and dq_oe=0 at that edge.
//    The transaction is dropped and no resp_valid is issued.
//  - req_valid while busy is held off by req_ready=0; no queuing.
// STRUCTURE
//  - sram_defs.vh: FSM state encodings, SRAM_AW=19, SRAM_DW=16, BUS_DW=32.
//  - Single FSM plus a wait counter ($clog2(WAIT_CYCLES+1) bits) and a half-select bit.
//  - No sub-module.
//  - Tristate buffer lives in the board top-level: data = dq_oe ? dq_o : 16'bz.
// TESTING
//  Bench uses a behavioural SRAM model that checks ce/oe/we/dq_oe overlap and setup/hold.
//  1 Write addr=18'h00010, be=4'hF, wdata=32'hDEADBEEF; then read the same address.
//    -> SRAM[0x20]=16'hBEEF, SRAM[0x21]=16'hDEAD.
//    -> Read resp_rdata=32'hDEADBEEF after 2*(1+W)+1 cycles.
//  2 Preload word 32'h11223344, then write be=4'b0100, wdata=32'h00AA0000.
//    -> Only the high half is cycled, with lb_n=0 and ub_n=1.
//    -> Read-back gives 32'h11AA3344.
//  3 Write be=4'h0 -> no ce_n assertion; resp_valid exactly 1 cycle after accept.
//  4 Three back-to-back requests with req_valid held high -> each accepted in the cycle its
//    predecessor's resp_valid pulses; no idle gap; dq_oe never overlaps oe_n=0.
//  5 Assert rst during the write STROBE phase.
//    -> Next cycle: we_n=1, ce_n=1, dq_oe=0, req_ready=1, no resp_valid.
//  6 WAIT_CYCLES=3, read addr=18'h3FFFF -> sram_addr 19'h7FFFE then 19'h7FFFF.
//    -> oe_n low for 3 cycles per half; latency 9 cycles.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// Shared widths, FSM encoding and half-word helpers for the SRAM controller.
package sram_ctrl_pkg;

    localparam int SRAM_AW = 19;
    localparam int SRAM_DW = 16;
    localparam int BUS_DW  = 32;
    localparam int REQ_AW  = 18;
    localparam int BE_W    = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETUP   = 2'd1,
        ST_STROBE  = 2'd2,
        ST_RECOVER = 2'd3
    } state_e;

    function automatic logic [SRAM_DW-1:0] half_data(input logic [BUS_DW-1:0] w, input logic hi);
        return hi ? w[31:16] : w[15:0];
    endfunction

    function automatic logic [1:0] half_be(input logic [BE_W-1:0] be, input logic hi);
        return hi ? be[3:2] : be[1:0];
    endfunction

endpackage

// File: rtl/sram_ctrl.sv
// Splits 32-bit bus requests into two 16-bit asynchronous SRAM accesses
// (low half first) with registered strobes and setup/strobe/recover phases.
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int WAIT_CYCLES = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [REQ_AW-1:0]   req_addr,
    input  logic [BE_W-1:0]     req_be,
    input  logic [BUS_DW-1:0]   req_wdata,
    output logic                resp_valid,
    output logic [BUS_DW-1:0]   resp_rdata,
    output logic [SRAM_AW-1:0]  sram_addr,
    output logic                sram_ce_n,
    output logic                sram_oe_n,
    output logic                sram_we_n,
    output logic                sram_ub_n,
    output logic                sram_lb_n,
    output logic [SRAM_DW-1:0]  sram_dq_o,
    output logic                sram_dq_oe,
    input  logic [SRAM_DW-1:0]  sram_dq_i,
    output state_e              dbg_state_o
);

    localparam int CW = $clog2(WAIT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES - 1);

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                half_q, half_d;
    logic                we_q, we_d;
    logic [REQ_AW-1:0]   addr_q, addr_d;
    logic [BE_W-1:0]     be_q, be_d;
    logic [BUS_DW-1:0]   wdata_q, wdata_d;
    logic                resp_valid_q, resp_valid_d;
    logic [BUS_DW-1:0]   rdata_q, rdata_d;
    logic [SRAM_AW-1:0]  sram_addr_q, sram_addr_d;
    logic                ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d;
    logic                ub_n_q, ub_n_d, lb_n_q, lb_n_d;
    logic [SRAM_DW-1:0]  dq_q, dq_d;
    logic                dq_oe_q, dq_oe_d;

    // Handshake: a request transfers on a cycle with req_valid & req_ready;
    // req_ready is high exactly while the FSM sits in IDLE.
    assign req_ready = (state_q == ST_IDLE);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        half_d       = half_q;
        we_d         = we_q;
        addr_d       = addr_q;
        be_d         = be_q;
        wdata_d      = wdata_q;
        resp_valid_d = 1'b0;
        rdata_d      = rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    be_d    = req_be;
                    wdata_d = req_wdata;
                    if (req_we && (req_be == '0)) begin
                        resp_valid_d = 1'b1;
                    end else begin
                        state_d = ST_SETUP;
                        // A write with no low-lane enables starts on the high half.
                        half_d  = req_we && (req_be[1:0] == 2'b00);
                    end
                end
            end
            ST_SETUP: begin
                state_d = ST_STROBE;
                cnt_d   = '0;
            end
            ST_STROBE: begin
                if (cnt_q == CNT_LAST) begin
                    if (we_q) begin
                        state_d = ST_RECOVER;
                    end else begin
                        if (half_q) rdata_d[31:16] = sram_dq_i;
                        else        rdata_d[15:0]  = sram_dq_i;
                        if (!half_q) begin
                            state_d = ST_SETUP;
                            half_d  = 1'b1;
                        end else begin
                            state_d      = ST_IDLE;
                            resp_valid_d = 1'b1;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RECOVER: begin
                if (!half_q && (be_q[3:2] != 2'b00)) begin
                    state_d = ST_SETUP;
                    half_d  = 1'b1;
                end else begin
                    state_d      = ST_IDLE;
                    resp_valid_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Pin values are a function of the state being entered, so they leave flops.
        sram_addr_d = sram_addr_q;
        dq_d        = dq_q;
        ce_n_d      = 1'b1;
        oe_n_d      = 1'b1;
        we_n_d      = 1'b1;
        ub_n_d      = 1'b1;
        lb_n_d      = 1'b1;
        dq_oe_d     = 1'b0;
        if (state_d != ST_IDLE) begin
            ce_n_d           = 1'b0;
            sram_addr_d      = {addr_d, half_d};
            {ub_n_d, lb_n_d} = we_d ? ~half_be(be_d, half_d) : 2'b00;
            dq_oe_d          = we_d;
            if (we_d) dq_d   = half_data(wdata_d, half_d);
            oe_n_d           = !((state_d == ST_STROBE) && !we_d);
            we_n_d           = !((state_d == ST_STROBE) && we_d);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            half_q       <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            be_q         <= '0;
            wdata_q      <= '0;
            resp_valid_q <= 1'b0;
            rdata_q      <= '0;
            sram_addr_q  <= '0;
            ce_n_q       <= 1'b1;
            oe_n_q       <= 1'b1;
            we_n_q       <= 1'b1;
            ub_n_q       <= 1'b1;
            lb_n_q       <= 1'b1;
            dq_q         <= '0;
            dq_oe_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            half_q       <= half_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            be_q         <= be_d;
            wdata_q      <= wdata_d;
            resp_valid_q <= resp_valid_d;
            rdata_q      <= rdata_d;
            sram_addr_q  <= sram_addr_d;
            ce_n_q       <= ce_n_d;
            oe_n_q       <= oe_n_d;
            we_n_q       <= we_n_d;
            ub_n_q       <= ub_n_d;
            lb_n_q       <= lb_n_d;
            dq_q         <= dq_d;
            dq_oe_q      <= dq_oe_d;
        end
    end

    assign resp_valid  = resp_valid_q;
    assign resp_rdata  = rdata_q;
    assign sram_addr   = sram_addr_q;
    assign sram_ce_n   = ce_n_q;
    assign sram_oe_n   = oe_n_q;
    assign sram_we_n   = we_n_q;
    assign sram_ub_n   = ub_n_q;
    assign sram_lb_n   = lb_n_q;
    assign sram_dq_o   = dq_q;
    assign sram_dq_oe  = dq_oe_q;
    assign dbg_state_o = state_q;

endmodule
